// File: rtl/flag_branch_unit.sv
// Conditional-branch resolver on the FLAG register read side: counts in-flight
// flag writers, holds a captured branch until its flags are committed, then pulses the outcome.
module flag_branch_unit #(
  parameter int MAX_PEND = 3,
  parameter int PEND_W   = 2,
  parameter int IMM_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       flag_in,
  input  logic             flag_wr_issue,
  input  logic             flag_wr_commit,
  input  logic             br_valid,
  input  logic [2:0]       br_ccc,
  input  logic             br_is_reg,
  input  logic [15:0]      br_pc_plus2,
  input  logic [IMM_W-1:0] br_imm,
  input  logic [15:0]      br_reg_target,
  input  logic             flush,
  output logic             br_ready,
  output logic             stall,
  output logic             resolve_valid,
  output logic             taken,
  output logic [15:0]      target,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] CCC_ALWAYS = 3'b111;

  state_t             state_q, state_d;
  logic [PEND_W-1:0]  pend_q;
  logic               capture, eval_now, clear, cond_met;
  logic [2:0]         cap_ccc;
  logic               cap_is_reg;
  logic [15:0]        cap_pc_plus2, cap_reg_target, offset, target_calc;
  logic [IMM_W-1:0]   cap_imm;

  // Pending flag writers; simultaneous issue and commit cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      err    <= 1'b0;
    end else if (flag_wr_issue && !flag_wr_commit) begin
      if (pend_q == PEND_W'(MAX_PEND)) err    <= 1'b1;
      else                             pend_q <= pend_q + 1'b1;
    end else if (flag_wr_commit && !flag_wr_issue) begin
      if (pend_q == '0) err    <= 1'b1;
      else              pend_q <= pend_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign clear = (pend_q == '0) && !flag_wr_issue;

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    eval_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && br_valid) begin
          capture = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (clear || cap_ccc == CCC_ALWAYS) begin
          eval_now = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign br_ready      = (state_q == IDLE);
  assign stall         = (state_q == EVAL);
  assign resolve_valid = (state_q == RESP) && !flush;

  // NOTE: captured operands carry no reset; they are only consumed after a capture in IDLE.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_ccc        <= br_ccc;
      cap_is_reg     <= br_is_reg;
      cap_pc_plus2   <= br_pc_plus2;
      cap_imm        <= br_imm;
      cap_reg_target <= br_reg_target;
    end
  end

  // flag_in bit order is {Z, V, N}.
  always_comb begin
    cond_met = 1'b1;
    unique case (cap_ccc)
      3'b000:  cond_met = !flag_in[2];
      3'b001:  cond_met =  flag_in[2];
      3'b010:  cond_met = !flag_in[2] && !flag_in[0];
      3'b011:  cond_met =  flag_in[0];
      3'b100:  cond_met =  flag_in[2] || !flag_in[0];
      3'b101:  cond_met =  flag_in[2] ||  flag_in[0];
      3'b110:  cond_met =  flag_in[1];
      default: cond_met = 1'b1;
    endcase
  end

  assign offset = {{(15-IMM_W){cap_imm[IMM_W-1]}}, cap_imm, 1'b0};

  always_comb begin
    target_calc = cap_pc_plus2;
    if (cond_met) target_calc = cap_is_reg ? cap_reg_target : cap_pc_plus2 + offset;
  end

  // Outcome registers hold until the next evaluation; resolve_valid qualifies them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken  <= 1'b0;
      target <= '0;
    end else if (eval_now) begin
      taken  <= cond_met;
      target <= target_calc;
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed pipeline-hazard scenarios plus
// randomized branches compared against a condition-table / arithmetic reference model.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  flag_in;
  logic        flag_wr_issue, flag_wr_commit;
  logic        br_valid;
  logic [2:0]  br_ccc;
  logic        br_is_reg;
  logic [15:0] br_pc_plus2;
  logic [8:0]  br_imm;
  logic [15:0] br_reg_target;
  logic        flush;
  logic        br_ready, stall, resolve_valid, taken, err;
  logic [15:0] target;

  int tests_run    = 0;
  int tests_failed = 0;

  flag_branch_unit #(.MAX_PEND(3), .PEND_W(2), .IMM_W(9)) dut (
    .clk(clk), .rst(rst), .flag_in(flag_in),
    .flag_wr_issue(flag_wr_issue), .flag_wr_commit(flag_wr_commit),
    .br_valid(br_valid), .br_ccc(br_ccc), .br_is_reg(br_is_reg),
    .br_pc_plus2(br_pc_plus2), .br_imm(br_imm), .br_reg_target(br_reg_target),
    .flush(flush), .br_ready(br_ready), .stall(stall),
    .resolve_valid(resolve_valid), .taken(taken), .target(target), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Condition table over named flags.
  function automatic bit model_taken(input logic [2:0] ccc, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Next PC with plain integer arithmetic, reduced modulo 2^16.
  function automatic logic [15:0] model_target(input bit tk, input bit is_reg,
      input logic [15:0] pc, input logic [8:0] imm, input logic [15:0] regt);
    int off, t;
    if (!tk) return pc;
    if (is_reg) return regt;
    off = int'(imm);
    if (off >= 256) off = off - 512;
    t = int'(pc) + 2 * off;
    t = ((t % 65536) + 65536) % 65536;
    return t[15:0];
  endfunction

  // Presents one branch while the unit is idle and checks latency, outcome and hold.
  task automatic run_branch(input logic [2:0] ccc, input bit is_reg, input logic [15:0] pc,
      input logic [8:0] imm, input logic [15:0] regt, input int exp_lat, input string tag);
    int          lat;
    bit          exp_tk;
    logic [15:0] exp_tg;
    check({tag, "_ready"}, br_ready, 1);
    br_valid = 1'b1; br_ccc = ccc; br_is_reg = is_reg;
    br_pc_plus2 = pc; br_imm = imm; br_reg_target = regt;
    step();
    br_valid = 1'b0;
    lat = 1;
    while (!resolve_valid && lat < 20) begin
      step();
      lat++;
    end
    exp_tk = model_taken(ccc, flag_in);
    exp_tg = model_target(exp_tk, is_reg, pc, imm, regt);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_taken"}, taken, exp_tk);
    check({tag, "_target"}, target, exp_tg);
    step();
    check({tag, "_pulse_one_cycle"}, {resolve_valid, br_ready}, 2'b01);
    check({tag, "_hold"}, {taken, target}, {exp_tk, exp_tg});
  endtask

  initial begin
    rst = 1'b0; flag_in = 3'b000; flag_wr_issue = 1'b0; flag_wr_commit = 1'b0;
    br_valid = 1'b0; br_ccc = 3'b000; br_is_reg = 1'b0; br_pc_plus2 = '0;
    br_imm = '0; br_reg_target = '0; flush = 1'b0;
    step(); step();
    check("rst_br_ready", br_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_resolve_valid", resolve_valid, 0);
    check("rst_taken", taken, 0);
    check("rst_target", target, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    step();

    // EQ with Z set, PC-relative
    flag_in = 3'b100;
    run_branch(3'b001, 1'b0, 16'h0100, 9'h005, 16'h0000, 2, "beq");
    check("beq_target_const", target, 16'h010A);

    // Writer issued cycle 0, branch cycle 1, commit cycle 3, new flags visible cycle 4
    flag_wr_issue = 1'b1;
    step();
    flag_wr_issue = 1'b0;
    br_valid = 1'b1; br_ccc = 3'b000; br_is_reg = 1'b1;
    br_reg_target = 16'h1234; br_pc_plus2 = 16'h0200;
    step();
    br_valid = 1'b0;
    check("hazard_c2", {stall, resolve_valid}, 2'b10);
    step();
    check("hazard_c3", {stall, resolve_valid}, 2'b10);
    flag_wr_commit = 1'b1;
    step();
    flag_wr_commit = 1'b0;
    flag_in = 3'b000;
    check("hazard_c4", {stall, resolve_valid}, 2'b10);
    step();
    check("hazard_c5", {stall, resolve_valid, taken}, 3'b011);
    check("hazard_target", target, 16'h1234);
    step();

    // Always-taken bypasses two pending writers
    flag_wr_issue = 1'b1;
    step(); step();
    flag_wr_issue = 1'b0;
    run_branch(3'b111, 1'b0, 16'h0000, 9'h1FF, 16'h0000, 2, "always_neg");
    check("always_neg_const", target, 16'hFFFE);
    run_branch(3'b111, 1'b0, 16'hFF02, 9'h0FF, 16'h0000, 2, "always_wrap");
    check("always_wrap_const", target, 16'h0100);
    flag_wr_commit = 1'b1;
    step(); step();
    flag_wr_commit = 1'b0;
    check("drained_no_err", err, 0);

    // Every condition against every flag combination, register target
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        flag_in = 3'(f);
        run_branch(3'(c), 1'b1, 16'($urandom), 9'($urandom), 16'hBEEF, 2,
                   $sformatf("br_c%0d_f%0d", c, f));
      end
    end

    // Random B/BR branches
    for (int i = 0; i < 40; i++) begin
      flag_in = 3'($urandom);
      run_branch(3'($urandom), 1'($urandom), 16'($urandom), 9'($urandom),
                 16'($urandom), 2, $sformatf("rnd%0d", i));
    end

    // Simultaneous issue and commit at count 1: count stays 1, branch waits
    flag_in = 3'b100;
    flag_wr_issue = 1'b1;
    step();
    br_valid = 1'b1; br_ccc = 3'b001; br_is_reg = 1'b0;
    br_pc_plus2 = 16'h0400; br_imm = 9'h010;
    flag_wr_commit = 1'b1;
    step();
    br_valid = 1'b0; flag_wr_issue = 1'b0; flag_wr_commit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("same_cycle_wait%0d", k), {stall, resolve_valid}, 2'b10);
      step();
    end
    flag_wr_commit = 1'b1;
    step();
    flag_wr_commit = 1'b0;
    check("same_cycle_eval", {stall, resolve_valid}, 2'b10);
    step();
    check("same_cycle_resolve", {resolve_valid, taken}, 2'b11);
    check("same_cycle_target", target, 16'h0420);
    check("same_cycle_no_err", err, 0);
    step();

    // Flush while waiting in EVAL
    flag_wr_issue = 1'b1;
    step();
    flag_wr_issue = 1'b0;
    br_valid = 1'b1; br_ccc = 3'b010;
    step();
    br_valid = 1'b0;
    check("flush_eval_pre", stall, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_eval_post", {br_ready, stall, resolve_valid}, 3'b100);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("flush_eval_quiet%0d", k), resolve_valid, 0);
      step();
    end
    flag_wr_commit = 1'b1;
    step();
    flag_wr_commit = 1'b0;

    // Flush in IDLE overrides br_valid
    br_valid = 1'b1; br_ccc = 3'b111; flush = 1'b1;
    step();
    br_valid = 1'b0; flush = 1'b0;
    check("flush_idle", {br_ready, stall}, 2'b10);

    // Flush in RESP suppresses the pulse
    br_valid = 1'b1; br_ccc = 3'b111;
    step();
    br_valid = 1'b0;
    step();
    check("resp_reached", resolve_valid, 1);
    flush = 1'b1;
    #1;
    check("flush_resp_masked", resolve_valid, 0);
    step();
    flush = 1'b0;
    check("flush_resp_post", {br_ready, resolve_valid}, 2'b10);

    // Commit at count 0 sets sticky err and leaves the count at 0
    flag_wr_commit = 1'b1;
    step();
    flag_wr_commit = 1'b0;
    check("err_set", err, 1);
    step(); step(); step();
    check("err_sticky", err, 1);
    flag_in = 3'b000;
    run_branch(3'b000, 1'b0, 16'h0800, 9'h002, 16'h0000, 2, "after_underflow");
    check("err_still_sticky", err, 1);

    // Reset during RESP
    br_valid = 1'b1; br_ccc = 3'b111; br_is_reg = 1'b1; br_reg_target = 16'hA5A5;
    step();
    br_valid = 1'b0;
    step();
    check("rst_resp_reached", resolve_valid, 1);
    rst = 1'b0;
    #1;
    check("rst_resp_outputs", {resolve_valid, br_ready, stall, err, taken}, 5'b01000);
    check("rst_resp_target", target, 0);
    step();
    rst = 1'b1;
    step();
    check("rst_resp_after", {br_ready, resolve_valid}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Reader side of the 3-bit FLAG register: consumes the registered {Z,V,N} flags and resolves conditional branches.
- Tracks in-flight flag-writing instructions and holds a branch until the flags it depends on are committed.
- Produces a one-cycle resolution pulse with the taken decision and the next-PC target.
- Sits between decode and the PC-select logic of the 16-bit pipelined core.

Parameters:
- MAX_PEND, 3: maximum flag-writing instructions in flight between issue and commit.
- PEND_W, 2: width of the pending counter; must hold MAX_PEND.
- IMM_W, 9: width of the B-type signed word offset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flag_in  in  3  FLAG register output: [2]=Z, [1]=V, [0]=N
- flag_wr_issue  in  1  an older flag-writing instruction entered EX this cycle
- flag_wr_commit  in  1  FLAG register write enable asserted this cycle
- br_valid  in  1  branch request present
- br_ccc  in  3  condition code
- br_is_reg  in  1  1 = BR (register target), 0 = B (PC-relative)
- br_pc_plus2  in  16  address of branch + 2
- br_imm  in  IMM_W  signed word offset (B only)
- br_reg_target  in  16  register target (BR only)
- flush  in  1  abandon the captured branch
- br_ready  out  1  unit can accept a branch
- stall  out  1  hold the front end
- resolve_valid  out  1  one-cycle resolution pulse
- taken  out  1  branch taken, valid with resolve_valid
- target  out  16  next PC, valid with resolve_valid
- err  out  1  sticky pending-count overflow/underflow

Behaviour:
- Reset (rst low, async): state IDLE, pending count 0; br_ready=1; stall, resolve_valid, taken, err=0; target=0.
- Pending counter, per clock edge:
  - issue only: +1.
  - commit only: -1.
  - both or neither: unchanged.
  - issue at MAX_PEND: count held, err set.
  - commit at 0: count held, err set.
  - err clears only on reset.
- FSM:
  - IDLE: br_ready=1, stall=0. On br_valid, capture all br_* inputs and go to EVAL.
  - EVAL: br_ready=0, stall=1. "Clear" means the registered count is 0 and flag_wr_issue=0.
    - If clear, or if ccc=111, evaluate using the current flag_in, register taken/target, go to RESP.
    - Otherwise stay in EVAL.
  - RESP: resolve_valid=1 for exactly one cycle, stall=0, br_ready=0; next state IDLE.
- Latency: br_valid in cycle N with no pending writers gives resolve_valid in cycle N+2. Each extra pending cycle adds one.
- A commit in cycle M updates flag_in at edge M+1. The count reaches 0 at the same edge, so evaluation always sees the committed flags.
- Conditions (Z,V,N):
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: Z | N
  - 110 OVFL: V
  - 111 always taken
- Target:
  - Not taken: br_pc_plus2.
  - Taken B: br_pc_plus2 + (sign-extended br_imm << 1), modulo 2^16.
  - Taken BR: br_reg_target.
  - taken and target hold their values until the next RESP; resolve_valid is the only qualifier.
- flush:
  - In EVAL or RESP: next state IDLE, no resolve_valid. If in RESP, resolve_valid is forced to 0 that cycle.
  - Pending counter is unaffected.
  - In IDLE: flush overrides br_valid (no capture).
- br_valid outside IDLE is ignored; the producer must honour br_ready.
- Reset mid-EVAL or mid-RESP: immediate return to reset values; no pulse.

Test Plan:
- Count 0, flags Z=1, ccc=001, B, pc_plus2=0x0100, imm=0x005 -> resolve_valid in cycle N+2, taken=1, target=0x010A.
- Issue in cycle 0, branch ccc=000 in cycle 1, commit with Z=0 in cycle 3 -> stall high in cycles 2-4, resolve in cycle 5, taken=1.
- B with imm=0x1FF, pc_plus2=0x0000, ccc=111, with 2 writers pending -> no wait, resolve in N+2, target=0xFFFE. Also imm=0x0FF at pc_plus2=0xFF02 -> target=0x0100 (wrap).
- All eight ccc values against all eight flag combinations, BR with reg_target=0xBEEF -> taken matches the condition table; target is 0xBEEF when taken, pc_plus2 when not.
- Simultaneous issue and commit at count 1 -> count stays 1, branch waits. Commit at count 0 -> err=1 and stays 1 until reset.
- Flush during EVAL, and rst low during RESP -> no resolve_valid, br_ready=1 on the next cycle.
